// File: rtl/sseg_capture.sv
// sseg_capture: debounces an active-low 7-segment bus, decodes it back to a hex
// nibble and presents each newly stable glyph once over a valid/ready handshake.
module sseg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       I_CLK,
    input  logic       I_RST,
    input  logic [6:0] I_SSEG,
    input  logic       I_READY,
    input  logic       I_CLR,
    output logic [3:0] O_DATA,
    output logic       O_VALID,
    output logic       O_ERROR,
    output logic       O_BLANK,
    output logic       O_OVERRUN
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;
    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);
    localparam logic [6:0] SSEG_BLANK = 7'h7F;

    logic [6:0] sample;
    logic [6:0] last_rep;
    logic [7:0] stable_cnt;
    logic [0:0] state;
    logic       stable_evt;
    logic [3:0] dec_data;
    logic       dec_error;
    logic       dec_blank;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            sample     <= SSEG_BLANK;
            stable_cnt <= '0;
        end else begin
            sample <= I_SSEG;
            if (I_SSEG != sample) begin
                stable_cnt <= 8'd1;
            end else if (stable_cnt < STABLE_LIM) begin
                stable_cnt <= stable_cnt + 8'd1;
            end
        end
    end

    // Comparing against the last reported pattern suppresses both repeats of a
    // held glyph and glitches that settle back onto it.
    assign stable_evt = (stable_cnt == STABLE_LIM) && (sample != last_rep);

    always_comb begin
        dec_data  = '0;
        dec_error = 1'b0;
        dec_blank = 1'b0;
        case (sample)
            7'b1000000: dec_data = 4'h0;
            7'b1111001: dec_data = 4'h1;
            7'b0100100: dec_data = 4'h2;
            7'b0110000: dec_data = 4'h3;
            7'b0011001: dec_data = 4'h4;
            7'b0010010: dec_data = 4'h5;
            7'b0000010: dec_data = 4'h6;
            7'b1111000: dec_data = 4'h7;
            7'b0000000: dec_data = 4'h8;
            7'b0010000: dec_data = 4'h9;
            7'b0001000: dec_data = 4'hA;
            7'b0000011: dec_data = 4'hB;
            7'b0100111: dec_data = 4'hC;
            7'b0100001: dec_data = 4'hD;
            7'b0000110: dec_data = 4'hE;
            7'b0001110: dec_data = 4'hF;
            SSEG_BLANK: dec_blank = 1'b1;
            default:    dec_error = 1'b1;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state     <= ST_IDLE;
            last_rep  <= SSEG_BLANK;
            O_DATA    <= '0;
            O_ERROR   <= 1'b0;
            O_BLANK   <= 1'b0;
            O_OVERRUN <= 1'b0;
        end else begin
            if (stable_evt) begin
                last_rep <= sample;
                O_DATA   <= dec_data;
                O_ERROR  <= dec_error;
                O_BLANK  <= dec_blank;
                state    <= ST_PENDING;
            end else if (state == ST_PENDING && I_READY) begin
                O_DATA  <= '0;
                O_ERROR <= 1'b0;
                O_BLANK <= 1'b0;
                state   <= ST_IDLE;
            end

            // Setting takes priority over a simultaneous clear.
            if (stable_evt && state == ST_PENDING && !I_READY) begin
                O_OVERRUN <= 1'b1;
            end else if (I_CLR) begin
                O_OVERRUN <= 1'b0;
            end
        end
    end

    assign O_VALID = (state == ST_PENDING);

endmodule

// File: tb/tb_sseg_capture.sv
// tb_sseg_capture: directed and randomized checks of sseg_capture against a
// history-based reference model evaluated every cycle.
module tb_sseg_capture;

    localparam int unsigned STABLE = 4;

    logic       I_CLK   = 1'b0;
    logic       I_RST   = 1'b1;
    logic [6:0] I_SSEG  = 7'h7F;
    logic       I_READY = 1'b0;
    logic       I_CLR   = 1'b0;
    logic [3:0] O_DATA;
    logic       O_VALID;
    logic       O_ERROR;
    logic       O_BLANK;
    logic       O_OVERRUN;

    int checks = 0;
    int errors = 0;

    sseg_capture #(.STABLE_CYCLES(STABLE)) dut (
        .I_CLK     (I_CLK),
        .I_RST     (I_RST),
        .I_SSEG    (I_SSEG),
        .I_READY   (I_READY),
        .I_CLR     (I_CLR),
        .O_DATA    (O_DATA),
        .O_VALID   (O_VALID),
        .O_ERROR   (O_ERROR),
        .O_BLANK   (O_BLANK),
        .O_OVERRUN (O_OVERRUN)
    );

    always #5 I_CLK = ~I_CLK;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: sample history since reset plus the reported outputs.
    logic [6:0] m_hist [$];
    logic [6:0] m_last  = 7'h7F;
    logic       m_pend  = 1'b0;
    logic [3:0] m_data  = '0;
    logic       m_err   = 1'b0;
    logic       m_blank = 1'b0;
    logic       m_ovr   = 1'b0;

    // Returns {error, blank, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == p) return {2'b00, 4'(i)};
        end
        if (p == 7'h7F) return 6'b010000;
        return 6'b100000;
    endfunction

    task automatic model_step();
        int         run;
        logic [6:0] cur;
        logic [5:0] d;
        bit         ev;
        if (I_RST) begin
            m_hist.delete();
            m_last  = 7'h7F;
            m_pend  = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
            m_blank = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        run = 0;
        ev  = 1'b0;
        cur = 7'h7F;
        if (m_hist.size() > 0) begin
            cur = m_hist[m_hist.size() - 1];
            for (int i = m_hist.size() - 1; i >= 0; i--) begin
                if (m_hist[i] != cur) break;
                run++;
            end
            ev = (run >= int'(STABLE)) && (cur != m_last);
        end
        if (ev && m_pend && !I_READY) m_ovr = 1'b1;
        else if (I_CLR)               m_ovr = 1'b0;
        if (ev) begin
            d       = decode(cur);
            m_last  = cur;
            m_pend  = 1'b1;
            m_err   = d[5];
            m_blank = d[4];
            m_data  = d[3:0];
        end else if (m_pend && I_READY) begin
            m_pend  = 1'b0;
            m_err   = 1'b0;
            m_blank = 1'b0;
            m_data  = '0;
        end
        m_hist.push_back(I_SSEG);
        if (m_hist.size() > 64) void'(m_hist.pop_front());
    endtask

    always begin
        @(posedge I_CLK or posedge I_RST);
        model_step();
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge I_CLK) begin
        check("model_data",    int'(O_DATA),    int'(m_data));
        check("model_valid",   int'(O_VALID),   int'(m_pend));
        check("model_error",   int'(O_ERROR),   int'(m_err));
        check("model_blank",   int'(O_BLANK),   int'(m_blank));
        check("model_overrun", int'(O_OVERRUN), int'(m_ovr));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge I_CLK);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},   int'(O_VALID),   0);
        check({tag, "_data"},    int'(O_DATA),    0);
        check({tag, "_error"},   int'(O_ERROR),   0);
        check({tag, "_blank"},   int'(O_BLANK),   0);
        check({tag, "_overrun"}, int'(O_OVERRUN), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(1);
        check_zero("reset");
        cyc(1);
        I_RST = 1'b0;

        // Power-up blank is never reported.
        cyc(20);
        check_zero("idle_blank");

        // Glyph 1 held from edge 1.
        I_SSEG = 7'b1111001;
        cyc(4);
        check("g1_early_valid", int'(O_VALID), 0);
        cyc(1);
        check("g1_valid", int'(O_VALID), 1);
        check("g1_data",  int'(O_DATA),  1);
        check("g1_error", int'(O_ERROR), 0);
        I_READY = 1'b1;
        cyc(1);
        I_READY = 1'b0;
        check("g1_ack_valid", int'(O_VALID), 0);
        cyc(10);
        check("g1_hold_valid", int'(O_VALID), 0);

        // Short A then short blank: filtered.
        I_SSEG = 7'b0001000;
        cyc(2);
        I_SSEG = 7'h7F;
        cyc(2);
        check("glitch_valid", int'(O_VALID), 0);
        I_SSEG = 7'b0001000;
        cyc(4);
        check("gA_early_valid", int'(O_VALID), 0);
        cyc(1);
        check("gA_valid", int'(O_VALID), 1);
        check("gA_data",  int'(O_DATA),  10);
        I_READY = 1'b1;
        cyc(1);
        check("gA_ack_valid", int'(O_VALID), 0);
        I_SSEG = 7'h7F;
        cyc(5);
        check("blank_valid", int'(O_VALID), 1);
        check("blank_flag",  int'(O_BLANK), 1);
        check("blank_data",  int'(O_DATA),  0);
        check("blank_error", int'(O_ERROR), 0);
        cyc(1);
        I_READY = 1'b0;

        // Illegal pattern.
        I_SSEG = 7'b1010101;
        cyc(5);
        check("err_valid", int'(O_VALID), 1);
        check("err_flag",  int'(O_ERROR), 1);
        check("err_blank", int'(O_BLANK), 0);
        check("err_data",  int'(O_DATA),  0);
        I_READY = 1'b1;
        cyc(1);
        I_READY = 1'b0;

        // Overrun: 3 pending, E overwrites it.
        I_SSEG = 7'b0110000;
        cyc(5);
        check("g3_data",    int'(O_DATA),    3);
        check("g3_overrun", int'(O_OVERRUN), 0);
        I_SSEG = 7'b0000110;
        cyc(5);
        check("gE_valid",   int'(O_VALID),   1);
        check("gE_data",    int'(O_DATA),    14);
        check("gE_overrun", int'(O_OVERRUN), 1);
        I_CLR = 1'b1;
        cyc(1);
        I_CLR = 1'b0;
        check("clr_overrun", int'(O_OVERRUN), 0);
        check("clr_valid",   int'(O_VALID),   1);
        I_SSEG = 7'b0110000;
        cyc(4);
        I_READY = 1'b1;
        cyc(1);
        I_READY = 1'b0;
        check("rdy_evt_valid",   int'(O_VALID),   1);
        check("rdy_evt_data",    int'(O_DATA),    3);
        check("rdy_evt_overrun", int'(O_OVERRUN), 0);
        I_READY = 1'b1;
        cyc(1);
        I_READY = 1'b0;

        // Async reset mid-count, then while pending.
        I_SSEG = 7'b0010010;
        cyc(2);
        #2 I_RST = 1'b1;
        #1 check_zero("rst_count");
        cyc(1);
        I_RST = 1'b0;
        cyc(4);
        check("rel1_early_valid", int'(O_VALID), 0);
        cyc(1);
        check("rel1_valid", int'(O_VALID), 1);
        check("rel1_data",  int'(O_DATA),  5);
        #2 I_RST = 1'b1;
        #1 check_zero("rst_pend");
        cyc(1);
        I_RST = 1'b0;
        cyc(4);
        check("rel2_early_valid", int'(O_VALID), 0);
        cyc(1);
        check("rel2_valid", int'(O_VALID), 1);
        check("rel2_data",  int'(O_DATA),  5);
        I_READY = 1'b1;
        cyc(1);
        I_READY = 1'b0;

        // Randomized segments of held patterns against the model.
        for (int seg = 0; seg < 600; seg++) begin
            int         sel;
            int         len;
            logic [6:0] pat;
            sel = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 8));
            if (sel <= 5)      pat = glyph[$urandom_range(0, 15)];
            else if (sel == 6) pat = 7'h7F;
            else if (sel == 7) pat = 7'($urandom);
            else if (sel == 8) pat = I_SSEG;
            else               pat = glyph[$urandom_range(0, 3)];
            I_SSEG = pat;
            for (int c = 0; c < len; c++) begin
                I_READY = ($urandom_range(0, 3) == 0);
                I_CLR   = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 399) == 0) begin
                    #3 I_RST = 1'b1;
                    #1 check_zero("rnd_rst");
                    cyc(1);
                    I_RST = 1'b0;
                end else begin
                    cyc(1);
                end
            end
        end
        I_READY = 1'b0;
        I_CLR   = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_capture.md
Name: sseg_capture

Overview:
- Reads a 7-segment drive bus back into hex nibbles: the reverse direction of the team's hex-to-segment encoder.
- Used as the loopback checker on display outputs and to decode segment patterns from external boards.
- Filters glitches by requiring each pattern to hold for a set number of cycles, then decodes it against the standard hex glyph table.
- Presents each new stable glyph once through a valid/ready handshake, with error, blank and overrun flags.

Parameters:
STABLE_CYCLES, 4, consecutive identical registered samples required before a pattern is accepted (legal range 1..255).

Ports:
I_CLK  input  1  system clock, all logic on rising edge
I_RST  input  1  asynchronous active-high reset
I_SSEG  input  7  segment bus, active-low, bit0=a .. bit6=g
I_READY  input  1  consumer accepts the pending result when high with O_VALID high
I_CLR  input  1  synchronous clear of O_OVERRUN
O_DATA  output  4  decoded nibble (0 when O_ERROR or O_BLANK)
O_VALID  output  1  result pending
O_ERROR  output  1  pending pattern is not a legal glyph and not blank
O_BLANK  output  1  pending pattern is all segments off (7'h7F)
O_OVERRUN  output  1  sticky: an unconsumed result was overwritten

Behaviour:
Reset:
- I_RST asserted at any time, including mid-count or mid-handshake, asynchronously clears everything.
- All outputs go to 0; the sample register and the last-reported register go to 7'h7F; the stability counter goes to 0.
- Power-up blank is therefore never reported.

Sampling:
- I_SSEG is registered every cycle into a sample register S.
- The counter resets to 1 on any edge where the incoming I_SSEG differs from S.
- Otherwise the counter increments, saturating at STABLE_CYCLES.
- Counter width is 8 bits.

Stable event:
- Fires for exactly one cycle when the counter first reaches STABLE_CYCLES and S differs from the last-reported register.
- On the event, the last-reported register loads S.
- Holding the same pattern never re-fires.
- A glitch that returns to the last-reported pattern fires nothing.

Latency:
- Pattern present before edge 1 and held: O_VALID rises at edge STABLE_CYCLES+1 (edge 5 at default).
- STABLE_CYCLES=1 gives O_VALID at edge 2.

Decode (active-low, g..a):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, B=0000011, C=0100111, D=0100001, E=0000110, F=0001110
- 1111111 sets O_BLANK=1, O_DATA=0.
- Anything else sets O_ERROR=1, O_DATA=0.
- O_ERROR and O_BLANK are never both high.

Handshake FSM:
- IDLE:
  - O_VALID=0.
  - On a stable event: load O_DATA, O_ERROR and O_BLANK; go to PENDING.
- PENDING:
  - O_VALID=1; O_DATA, O_ERROR and O_BLANK are held stable.
  - I_READY=1 with no event: go to IDLE and clear O_DATA, O_ERROR and O_BLANK to 0.
  - Event with I_READY=1 in the same cycle: load the new result, stay in PENDING, no overrun.
  - Event with I_READY=0: load the new result (latest wins), stay in PENDING, set O_OVERRUN.

Overrun flag:
- O_OVERRUN is cleared only by I_CLR or reset.
- If I_CLR and a set condition occur in the same cycle, set wins.

Test Plan:
- Reset, then hold I_SSEG=7'h7F for 20 cycles -> O_VALID stays 0, all outputs 0.
- Apply 1111001 held from edge 1, I_READY=0 -> O_VALID=1 at edge 5, O_DATA=1, O_ERROR=0. Pulse I_READY -> O_VALID=0 next edge. Keep holding -> no second event.
- 0001000 for 2 cycles, then 1111111 -> no event (glitch filtered). Then 0001000 held 4+ cycles -> O_DATA=A. Then 1111111 held -> event with O_BLANK=1, O_DATA=0.
- Apply 1010101 held -> O_VALID=1, O_ERROR=1, O_DATA=0.
- Pattern 3 accepted, no I_READY; pattern E becomes stable -> O_DATA=E, O_OVERRUN=1. I_CLR -> O_OVERRUN=0 while O_VALID stays 1. Repeat with I_READY high on the event cycle -> O_OVERRUN stays 0.
- Assert I_RST asynchronously mid-count (counter=2) and while in PENDING -> all outputs 0 immediately. Same pattern re-held after release -> reported again, O_VALID rises STABLE_CYCLES+1 edges after release.
